// File: rtl/dmem_bus_if_pkg.sv
// dmem_bus_if_pkg: shared state encodings and constants for the data-memory bus interface
package dmem_bus_if_pkg;
    typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_DONE} dmem_state_e;
    localparam logic READ = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam int unsigned DMEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: counts BUSY cycles and flags the last wait cycle allowed
module dmem_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    logic [7:0] cnt_q;
    always_ff @(posedge clk)
        if (!rst_n || clr_i) cnt_q <= '0;
        else if (inc_i) cnt_q <= cnt_q + 8'd1;
    assign expired_o = cnt_q == 8'(LIMIT - 1);
endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: runs MEM-stage RAM requests as Wishbone-classic cycles, stalling until ack/err/timeout
module dmem_bus_if
    import dmem_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEF,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ram_en_i,
    input  logic          ram_we_i,
    input  logic [3:0]    ram_sel_i,
    input  logic [DW-1:0] ram_addr_i,
    input  logic [DW-1:0] ram_data_i,
    output logic [DW-1:0] ram_data_o,
    output logic          stall_req_o,
    input  logic          pipe_stall_i,
    input  logic          flush_i,
    output logic          bus_err_o,
    output logic [DW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);
    dmem_state_e   state_q;
    logic [DW-1:0] adr_q, dat_q, rd_buf_q;
    logic [3:0]    sel_q;
    logic          we_q, cyc_q, stb_q, bus_err_q, flushed_q, expired;

    dmem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == DMEM_IDLE),
        .inc_i    (state_q == DMEM_BUSY),
        .expired_o(expired)
    );

    always_ff @(posedge clk)
        if (!rst_n) begin
            state_q   <= DMEM_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            rd_buf_q  <= '0;
            bus_err_q <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                DMEM_IDLE:
                    if (ram_en_i && !flush_i) begin
                        adr_q     <= ram_addr_i & ~DW'(3);
                        dat_q     <= ram_data_i;
                        sel_q     <= ram_sel_i;
                        we_q      <= ram_we_i;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        rd_buf_q  <= '0;
                        flushed_q <= 1'b0;
                        state_q   <= DMEM_BUSY;
                    end
                DMEM_BUSY: begin
                    if (flush_i) flushed_q <= 1'b1;
                    // err beats ack; ack beats a timeout in the same cycle
                    if (wb_err_i || (expired && !wb_ack_i)) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        rd_buf_q  <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= (flushed_q || flush_i) ? DMEM_IDLE : DMEM_DONE;
                    end else if (wb_ack_i) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        rd_buf_q <= (we_q == WRITE) ? '0 : wb_dat_i;
                        state_q  <= (flushed_q || flush_i) ? DMEM_IDLE : DMEM_DONE;
                    end
                end
                DMEM_DONE:
                    if (flush_i || !pipe_stall_i) state_q <= DMEM_IDLE;
                default: state_q <= DMEM_IDLE;
            endcase
        end

    assign stall_req_o = rst_n && ((state_q == DMEM_IDLE && ram_en_i && !flush_i) ||
                                   (state_q == DMEM_BUSY && !flushed_q));
    assign ram_data_o  = (state_q == DMEM_DONE) ? rd_buf_q : '0;
    assign bus_err_o   = bus_err_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed vectors for dmem_bus_if with a 4-cycle timeout
module tb_dmem_bus_if;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_en, ram_we, pipe_stall, flush, ack, err;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, wb_rdata;
    logic [31:0] ram_data, wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        stall_req, bus_err, wb_we, wb_cyc, wb_stb;
    int          n_chk = 0, n_pass = 0, n_st;

    always #5 clk = ~clk;

    dmem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ram_en_i    (ram_en),
        .ram_we_i    (ram_we),
        .ram_sel_i   (ram_sel),
        .ram_addr_i  (ram_addr),
        .ram_data_i  (ram_wdata),
        .ram_data_o  (ram_data),
        .stall_req_o (stall_req),
        .pipe_stall_i(pipe_stall),
        .flush_i     (flush),
        .bus_err_o   (bus_err),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat),
        .wb_sel_o    (wb_sel),
        .wb_we_o     (wb_we),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_dat_i    (wb_rdata),
        .wb_ack_i    (ack),
        .wb_err_i    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        ram_en = 1'b1; ram_we = we; ram_addr = addr; ram_wdata = data; ram_sel = sel;
    endtask

    initial begin
        rst_n = 1'b0; ram_en = 1'b0; ram_we = 1'b0; ram_sel = '0; ram_addr = '0; ram_wdata = '0;
        pipe_stall = 1'b0; flush = 1'b0; ack = 1'b0; err = 1'b0; wb_rdata = '0;
        step; step; #1;
        check("rst_cyc", wb_cyc, 0); check("rst_stb", wb_stb, 0); check("rst_stall", stall_req, 0);
        check("rst_rdata", ram_data, 0); check("rst_adr", wb_adr, 0); check("rst_err", bus_err, 0);
        step; rst_n = 1'b1;
        // load, zero wait states
        step; req(0, 32'h106, 0, 4'b0010); #1;
        check("ld_stall_idle", stall_req, 1); check("ld_cyc_idle", wb_cyc, 0);
        step; ack = 1'b1; wb_rdata = 32'hA1B2C3D4; #1;
        check("ld_stall_busy", stall_req, 1); check("ld_cyc", wb_cyc, 1); check("ld_stb", wb_stb, 1);
        check("ld_adr", wb_adr, 32'h104); check("ld_sel", wb_sel, 4'b0010); check("ld_we", wb_we, 0);
        check("ld_rdata_busy", ram_data, 0);
        step; ack = 1'b0; ram_en = 1'b0; #1;
        check("ld_stall_done", stall_req, 0); check("ld_rdata_done", ram_data, 32'hA1B2C3D4);
        check("ld_cyc_done", wb_cyc, 0);
        step; #1;
        check("ld_rdata_idle", ram_data, 0); check("ld_stall_idle2", stall_req, 0);
        // store, three wait states; ack lands on the last counter value
        step; req(1, 32'h20, 32'h11223344, 4'b1111); #1; n_st = int'(stall_req);
        for (int i = 0; i < 4; i++) begin
            step; ack = (i == 3); #1; n_st += int'(stall_req);
            check("st_cyc", wb_cyc, 1);
            if (i == 0) begin
                check("st_we", wb_we, 1); check("st_dat", wb_dat, 32'h11223344);
                check("st_adr", wb_adr, 32'h20); check("st_sel", wb_sel, 4'b1111);
            end
        end
        step; ack = 1'b0; ram_en = 1'b0; #1; n_st += int'(stall_req);
        check("st_rdata_done", ram_data, 0); check("st_err", bus_err, 0); check("st_cyc_done", wb_cyc, 0);
        check("st_stall_cycles", n_st, 5);
        step; #1;
        // timeout: slave never answers
        step; req(0, 32'h40, 0, 4'b1111); #1;
        for (int i = 0; i < 4; i++) begin
            step; #1; check("to_cyc_busy", wb_cyc, 1);
        end
        step; ram_en = 1'b0; #1;
        check("to_cyc", wb_cyc, 0); check("to_stb", wb_stb, 0); check("to_err", bus_err, 1);
        check("to_rdata", ram_data, 0); check("to_stall", stall_req, 0);
        step; #1; check("to_err_pulse", bus_err, 0);
        // err and ack together: err wins
        step; req(0, 32'h44, 0, 4'b1111); #1;
        step; err = 1'b1; ack = 1'b1; wb_rdata = 32'h12345678; #1; check("er_cyc", wb_cyc, 1);
        step; err = 1'b0; ack = 1'b0; ram_en = 1'b0; #1;
        check("er_err", bus_err, 1); check("er_rdata", ram_data, 0); check("er_cyc_done", wb_cyc, 0);
        step; #1; check("er_err_pulse", bus_err, 0);
        // flush in IDLE ignores the request
        step; ram_en = 1'b1; flush = 1'b1; #1; check("fi_stall", stall_req, 0);
        step; ram_en = 1'b0; flush = 1'b0; #1; check("fi_cyc", wb_cyc, 0);
        // flush during BUSY
        step; req(0, 32'h60, 0, 4'b1111); #1; check("fb_stall_idle", stall_req, 1);
        step; flush = 1'b1; #1; check("fb_stall_b1", stall_req, 1); check("fb_cyc_b1", wb_cyc, 1);
        step; flush = 1'b0; ram_en = 1'b0; #1; check("fb_stall_b2", stall_req, 0); check("fb_cyc_b2", wb_cyc, 1);
        step; ack = 1'b1; wb_rdata = 32'h55AA55AA; #1; check("fb_cyc_b3", wb_cyc, 1);
        step; ack = 1'b0; req(0, 32'h80, 0, 4'b1111); #1;
        check("fb_cyc_end", wb_cyc, 0); check("fb_rdata", ram_data, 0);
        check("fb_no_done", stall_req, 1); check("fb_err", bus_err, 0);
        // external stall holds DONE
        step; ack = 1'b1; wb_rdata = 32'hDEADBEEF; #1; check("es_cyc", wb_cyc, 1); check("es_adr", wb_adr, 32'h80);
        for (int i = 0; i < 4; i++) begin
            step; ack = 1'b0; pipe_stall = (i < 3); ram_en = (i < 3); #1;
            check("es_rdata", ram_data, 32'hDEADBEEF); check("es_cyc_done", wb_cyc, 0); check("es_stall", stall_req, 0);
        end
        step; #1; check("es_rdata_idle", ram_data, 0); check("es_cyc_idle", wb_cyc, 0);
        step; #1; check("es_no_reissue", wb_cyc, 0);
        // reset mid-BUSY
        step; req(1, 32'h90, 32'hCAFEF00D, 4'b1111); #1;
        step; rst_n = 1'b0; ram_en = 1'b0; #1; check("rb_cyc_busy", wb_cyc, 1);
        step; rst_n = 1'b1; #1;
        check("rb_cyc", wb_cyc, 0); check("rb_stb", wb_stb, 0); check("rb_we", wb_we, 0);
        check("rb_adr", wb_adr, 0); check("rb_dat", wb_dat, 0); check("rb_sel", wb_sel, 0);
        check("rb_stall", stall_req, 0); check("rb_err", bus_err, 0); check("rb_rdata", ram_data, 0);
        step; #1; check("rb_cyc_after", wb_cyc, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
